// File: rtl/zbuffer_resolve.sv
// rtl/zbuffer_resolve.sv - per-pixel depth test against a 64x64 z-buffer with colour commit and clear sweep
// Optional statistics counters are built when ZBUF_STATS_EN is defined.
module zbuffer_resolve #(
   parameter logic [8:0] CLEAR_DEPTH = 9'h1FF,
   parameter logic [9:0] CLEAR_COLOR = 10'h000,
   parameter int         STAT_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear_in,
   input  logic              valid_in,
   input  logic [30:0]       pixel_in,
   output logic              busy_out,
   output logic              pipe_empty,
   output logic              drop_err,
   input  logic [11:0]       rd_addr,
   output logic [9:0]        rd_color,
   output logic [STAT_W-1:0] stat_written,
   output logic [STAT_W-1:0] stat_rejected
);

   typedef enum logic {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [11:0] addr_cnt_q, addr_cnt_d;

   logic        s0_valid_q, s0_valid_d;
   logic [11:0] s0_addr_q;
   logic [8:0]  s0_z_q;
   logic [9:0]  s0_color_q;

   logic        s1_valid_q, s1_valid_d;
   logic [11:0] s1_addr_q;
   logic [8:0]  s1_z_q;
   logic [9:0]  s1_color_q;

   logic        last_wr_valid_q;
   logic [11:0] last_wr_addr_q;
   logic [8:0]  last_wr_z_q;

   logic        drop_err_q, drop_err_d;
   logic [9:0]  rd_color_q;
   logic [8:0]  depth_rd_q;

   logic [8:0]  depth_mem [4096];
   logic [9:0]  color_mem [4096];

   logic        clear_start;
   logic [11:0] pix_addr;
   logic [8:0]  eff_depth;
   logic        z_wins;
   logic        commit;

   assign busy_out    = (state_q == ST_CLEAR);
   assign clear_start = clear_in && (state_q == ST_IDLE);
   assign pix_addr    = {pixel_in[24:19], pixel_in[30:25]};

   // The RAM read for the S1 pixel was issued while the previous pixel was still being written.
   assign eff_depth = (last_wr_valid_q && (last_wr_addr_q == s1_addr_q)) ? last_wr_z_q : depth_rd_q;
   assign z_wins    = (s1_z_q < eff_depth);
   assign commit    = s1_valid_q && !clear_start && z_wins;

   assign pipe_empty = !(s0_valid_q || s1_valid_q);
   assign drop_err   = drop_err_q;
   assign rd_color   = rd_color_q;

   always_comb begin
      state_d    = state_q;
      addr_cnt_d = addr_cnt_q;
      case (state_q)
         ST_CLEAR: begin
            addr_cnt_d = addr_cnt_q + 12'd1;
            if (addr_cnt_q == 12'hFFF) begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (clear_in) begin
               state_d    = ST_CLEAR;
               addr_cnt_d = 12'd0;
            end
         end
         default: begin
            state_d    = ST_CLEAR;
            addr_cnt_d = 12'd0;
         end
      endcase
   end

   always_comb begin
      s0_valid_d = valid_in && (state_q == ST_IDLE) && !clear_in;
      s1_valid_d = s0_valid_q && !clear_start;
      drop_err_d = clear_start ? 1'b0 : (drop_err_q || (valid_in && busy_out));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= ST_CLEAR;
         addr_cnt_q      <= 12'd0;
         s0_valid_q      <= 1'b0;
         s0_addr_q       <= 12'd0;
         s0_z_q          <= 9'd0;
         s0_color_q      <= 10'd0;
         s1_valid_q      <= 1'b0;
         s1_addr_q       <= 12'd0;
         s1_z_q          <= 9'd0;
         s1_color_q      <= 10'd0;
         last_wr_valid_q <= 1'b0;
         last_wr_addr_q  <= 12'd0;
         last_wr_z_q     <= 9'd0;
         drop_err_q      <= 1'b0;
         rd_color_q      <= 10'd0;
      end else begin
         state_q         <= state_d;
         addr_cnt_q      <= addr_cnt_d;
         s0_valid_q      <= s0_valid_d;
         s0_addr_q       <= pix_addr;
         s0_z_q          <= pixel_in[18:10];
         s0_color_q      <= pixel_in[9:0];
         s1_valid_q      <= s1_valid_d;
         s1_addr_q       <= s0_addr_q;
         s1_z_q          <= s0_z_q;
         s1_color_q      <= s0_color_q;
         last_wr_valid_q <= commit;
         last_wr_addr_q  <= s1_addr_q;
         last_wr_z_q     <= s1_z_q;
         drop_err_q      <= drop_err_d;
         rd_color_q      <= color_mem[rd_addr];
      end
   end

   // Contents are deliberately not reset; the clear sweep initialises them.
   always_ff @(posedge clk) begin
      depth_rd_q <= depth_mem[s0_addr_q];
      if (busy_out) begin
         depth_mem[addr_cnt_q] <= CLEAR_DEPTH;
         color_mem[addr_cnt_q] <= CLEAR_COLOR;
      end else if (commit) begin
         depth_mem[s1_addr_q] <= s1_z_q;
         color_mem[s1_addr_q] <= s1_color_q;
      end
   end

`ifdef ZBUF_STATS_EN
   logic              reject;
   logic [STAT_W-1:0] written_q, written_d;
   logic [STAT_W-1:0] rejected_q, rejected_d;

   assign reject = s1_valid_q && !clear_start && !z_wins;

   always_comb begin
      written_d  = written_q;
      rejected_d = rejected_q;
      if (clear_start) begin
         written_d  = '0;
         rejected_d = '0;
      end else begin
         if (commit && (written_q != {STAT_W{1'b1}})) begin
            written_d = written_q + 1'b1;
         end
         if (reject && (rejected_q != {STAT_W{1'b1}})) begin
            rejected_d = rejected_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         written_q  <= '0;
         rejected_q <= '0;
      end else begin
         written_q  <= written_d;
         rejected_q <= rejected_d;
      end
   end

   assign stat_written  = written_q;
   assign stat_rejected = rejected_q;
`else
   assign stat_written  = '0;
   assign stat_rejected = '0;
`endif

endmodule

// File: tb/tb_zbuffer_resolve.sv
// tb/tb_zbuffer_resolve.sv - scoreboard bench for zbuffer_resolve against a behavioural z-buffer model
module tb_zbuffer_resolve;

   localparam int STAT_W = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              clear_in;
   logic              valid_in;
   logic [30:0]       pixel_in;
   logic              busy_out;
   logic              pipe_empty;
   logic              drop_err;
   logic [11:0]       rd_addr;
   logic [9:0]        rd_color;
   logic [STAT_W-1:0] stat_written;
   logic [STAT_W-1:0] stat_rejected;

   int pass_cnt = 0;
   int total_cnt = 0;

   logic [8:0] m_depth [4096];
   logic [9:0] m_color [4096];
   int         m_written;
   int         m_rejected;
   logic [9:0] exp_q [$];
   logic [9:0] got_c;
   logic [9:0] exp_c;

   zbuffer_resolve #(.STAT_W(STAT_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear_in     (clear_in),
      .valid_in     (valid_in),
      .pixel_in     (pixel_in),
      .busy_out     (busy_out),
      .pipe_empty   (pipe_empty),
      .drop_err     (drop_err),
      .rd_addr      (rd_addr),
      .rd_color     (rd_color),
      .stat_written (stat_written),
      .stat_rejected(stat_rejected)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
      $fatal(1, "watchdog");
   end

   function automatic int exp_stat(int v);
`ifdef ZBUF_STATS_EN
      return v;
`else
      return 0 * v;
`endif
   endfunction

   function automatic void m_clear();
      for (int i = 0; i < 4096; i++) begin
         m_depth[i] = 9'h1FF;
         m_color[i] = 10'h000;
      end
      m_written  = 0;
      m_rejected = 0;
   endfunction

   function automatic void m_pixel(int x, int y, int z, logic [9:0] c);
      int a;
      a = y * 64 + x;
      if (z < int'(m_depth[a])) begin
         m_depth[a] = z[8:0];
         m_color[a] = c;
         m_written++;
      end else begin
         m_rejected++;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_pixel(int x, int y, int z, logic [9:0] c);
      logic [5:0] xs;
      logic [5:0] ys;
      logic [8:0] zs;
      xs = x[5:0];
      ys = y[5:0];
      zs = z[8:0];
      pixel_in = {xs, ys, zs, c};
      valid_in = 1'b1;
   endtask

   task automatic wait_busy(output int n);
      n = 0;
      while (busy_out && n < 5000) begin
         n++;
         tick();
      end
   endtask

   task automatic test_reset();
      int n;
      rst_n = 1'b0;
      tick();
      tick();
      total_cnt++;
      if (busy_out !== 1'b1 || pipe_empty !== 1'b1 || drop_err !== 1'b0) begin
         $display("FAIL reset_flags: got busy=%b empty=%b drop=%b required 1 1 0", busy_out, pipe_empty, drop_err);
      end else pass_cnt++;
      total_cnt++;
      if (rd_color !== 10'h000 || stat_written !== '0 || stat_rejected !== '0) begin
         $display("FAIL reset_outputs: got rd_color=%h w=%0d r=%0d required 0 0 0", rd_color, stat_written, stat_rejected);
      end else pass_cnt++;
      rst_n = 1'b1;
      m_clear();
      wait_busy(n);
      total_cnt++;
      if (n !== 4096) $display("FAIL reset_sweep_len: got %0d cycles required 4096", n);
      else pass_cnt++;
      foreach (exp_q[i]) exp_q.delete();
      rd_addr = 12'h000;
      exp_q.push_back(m_color[0]);
      tick();
      got_c = rd_color;
      exp_c = exp_q.pop_front();
      total_cnt++;
      if (got_c !== exp_c) $display("FAIL reset_rd_000: got %h required %h", got_c, exp_c);
      else pass_cnt++;
      rd_addr = 12'hFFF;
      exp_q.push_back(m_color[4095]);
      tick();
      got_c = rd_color;
      exp_c = exp_q.pop_front();
      total_cnt++;
      if (got_c !== exp_c) $display("FAIL reset_rd_fff: got %h required %h", got_c, exp_c);
      else pass_cnt++;
   endtask

   task automatic test_single_pixel();
      drive_pixel(5, 3, 100, 10'h155);
      m_pixel(5, 3, 100, 10'h155);
      tick();
      valid_in = 1'b0;
      total_cnt++;
      if (pipe_empty !== 1'b0) $display("FAIL single_in_flight: got pipe_empty=%b required 0", pipe_empty);
      else pass_cnt++;
      tick();
      tick();
      rd_addr = 12'h0C5;
      exp_q.push_back(m_color[12'h0C5]);
      tick();
      got_c = rd_color;
      exp_c = exp_q.pop_front();
      total_cnt++;
      if (got_c !== exp_c) $display("FAIL single_rd_n3: got %h required %h", got_c, exp_c);
      else pass_cnt++;
      total_cnt++;
      if (pipe_empty !== 1'b1) $display("FAIL single_drained: got pipe_empty=%b required 1", pipe_empty);
      else pass_cnt++;
      total_cnt++;
      if (int'(stat_written) !== exp_stat(m_written))
         $display("FAIL single_written: got %0d required %0d", stat_written, exp_stat(m_written));
      else pass_cnt++;
   endtask

   task automatic test_same_addr();
      int zs [3] = '{200, 100, 50};
      logic [9:0] cs [3] = '{10'h0AA, 10'h0FF, 10'h2AA};
      for (int i = 0; i < 3; i++) begin
         drive_pixel(5, 3, zs[i], cs[i]);
         m_pixel(5, 3, zs[i], cs[i]);
         tick();
         valid_in = 1'b0;
         tick();
         tick();
         rd_addr = 12'h0C5;
         exp_q.push_back(m_color[12'h0C5]);
         tick();
         got_c = rd_color;
         exp_c = exp_q.pop_front();
         total_cnt++;
         if (got_c !== exp_c) $display("FAIL same_addr_%0d: got %h required %h", i, got_c, exp_c);
         else pass_cnt++;
      end
      total_cnt++;
      if (int'(stat_written) !== exp_stat(m_written) || int'(stat_rejected) !== exp_stat(m_rejected))
         $display("FAIL same_addr_stats: got w=%0d r=%0d required w=%0d r=%0d",
                  stat_written, stat_rejected, exp_stat(m_written), exp_stat(m_rejected));
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int n;
      int zs [3] = '{300, 200, 250};
      logic [9:0] cs [3] = '{10'h001, 10'h002, 10'h003};
      clear_in = 1'b1;
      tick();
      clear_in = 1'b0;
      m_clear();
      for (int i = 0; i < 100; i++) begin
         clear_in = (i == 50);
         tick();
      end
      clear_in = 1'b0;
      wait_busy(n);
      total_cnt++;
      if (n !== 3996) $display("FAIL clear_ignored_len: got %0d remaining cycles required 3996", n);
      else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         drive_pixel(10, 10, zs[i], cs[i]);
         m_pixel(10, 10, zs[i], cs[i]);
         tick();
      end
      valid_in = 1'b0;
      tick();
      tick();
      rd_addr = 12'h28A;
      exp_q.push_back(m_color[12'h28A]);
      tick();
      got_c = rd_color;
      exp_c = exp_q.pop_front();
      total_cnt++;
      if (got_c !== exp_c) $display("FAIL b2b_forward: got %h required %h", got_c, exp_c);
      else pass_cnt++;
      total_cnt++;
      if (int'(stat_written) !== exp_stat(m_written) || int'(stat_rejected) !== exp_stat(m_rejected))
         $display("FAIL b2b_stats: got w=%0d r=%0d required w=%0d r=%0d",
                  stat_written, stat_rejected, exp_stat(m_written), exp_stat(m_rejected));
      else pass_cnt++;
   endtask

   task automatic test_clear_drop();
      int n;
      int addrs [3] = '{12'h514, 12'h515, 12'h79E};
      drive_pixel(20, 20, 1, 10'h3FF);
      tick();
      drive_pixel(21, 20, 1, 10'h3FE);
      tick();
      valid_in = 1'b0;
      clear_in = 1'b1;
      tick();
      clear_in = 1'b0;
      m_clear();
      drive_pixel(30, 30, 5, 10'h1AB);
      tick();
      valid_in = 1'b0;
      total_cnt++;
      if (drop_err !== 1'b1) $display("FAIL drop_set: got drop_err=%b required 1", drop_err);
      else pass_cnt++;
      wait_busy(n);
      total_cnt++;
      if (n !== 4095) $display("FAIL drop_sweep_len: got %0d cycles required 4095", n);
      else pass_cnt++;
      total_cnt++;
      if (drop_err !== 1'b1) $display("FAIL drop_sticky: got drop_err=%b required 1", drop_err);
      else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         rd_addr = addrs[i][11:0];
         exp_q.push_back(m_color[addrs[i]]);
         tick();
         got_c = rd_color;
         exp_c = exp_q.pop_front();
         total_cnt++;
         if (got_c !== exp_c) $display("FAIL drop_mem_%03h: got %h required %h", addrs[i], got_c, exp_c);
         else pass_cnt++;
      end
      total_cnt++;
      if (int'(stat_written) !== exp_stat(m_written) || int'(stat_rejected) !== exp_stat(m_rejected))
         $display("FAIL drop_stats: got w=%0d r=%0d required w=%0d r=%0d",
                  stat_written, stat_rejected, exp_stat(m_written), exp_stat(m_rejected));
      else pass_cnt++;
      clear_in = 1'b1;
      tick();
      clear_in = 1'b0;
      total_cnt++;
      if (drop_err !== 1'b0) $display("FAIL drop_cleared: got drop_err=%b required 0", drop_err);
      else pass_cnt++;
      wait_busy(n);
   endtask

   task automatic test_reset_mid_sweep();
      int n;
      int errs;
      drive_pixel(63, 63, 7, 10'h3C3);
      m_pixel(63, 63, 7, 10'h3C3);
      tick();
      drive_pixel(0, 32, 9, 10'h155);
      m_pixel(0, 32, 9, 10'h155);
      tick();
      valid_in = 1'b0;
      tick();
      tick();
      clear_in = 1'b1;
      tick();
      clear_in = 1'b0;
      m_clear();
      for (int i = 0; i < 2000; i++) tick();
      rst_n = 1'b0;
      tick();
      total_cnt++;
      if (busy_out !== 1'b1 || pipe_empty !== 1'b1) $display("FAIL midrst_flags: got busy=%b empty=%b required 1 1", busy_out, pipe_empty);
      else pass_cnt++;
      rst_n = 1'b1;
      wait_busy(n);
      total_cnt++;
      if (n !== 4096) $display("FAIL midrst_sweep_len: got %0d cycles required 4096", n);
      else pass_cnt++;
      errs = 0;
      for (int a = 0; a < 4096; a++) begin
         rd_addr = a[11:0];
         exp_q.push_back(m_color[a]);
         tick();
         got_c = rd_color;
         exp_c = exp_q.pop_front();
         total_cnt++;
         if (got_c !== exp_c) $display("FAIL midrst_mem_%03h: got %h required %h", a, got_c, exp_c);
         else pass_cnt++;
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      clear_in = 1'b0;
      valid_in = 1'b0;
      pixel_in = '0;
      rd_addr  = '0;
      m_clear();
      test_reset();
      test_single_pixel();
      test_same_addr();
      test_back_to_back();
      test_clear_drop();
      test_reset_mid_sweep();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/zbuffer_resolve.md
Name: zbuffer_resolve

Overview:
- Sits directly downstream of the triangle rasterizer and consumes its per-pixel stream {x, y, z, color}.
- Performs a per-pixel depth test against a 64x64 depth buffer and commits winning colors to a 64x64 color buffer.
- The display/readout logic reads that color buffer through a separate read port.
- Provides a frame clear sweep, automatic clear after reset, and optional hit/reject statistics.

Parameters:
- CLEAR_DEPTH, 9'h1FF, depth written by the clear sweep (farthest).
- CLEAR_COLOR, 10'h000, color written by the clear sweep (background).
- STAT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- clear_in  input  1  single-cycle pulse; starts a clear sweep
- valid_in  input  1  pixel_in is valid this cycle; no backpressure to upstream
- pixel_in  input  31  {x[30:25], y[24:19], z[18:10], color[9:0]}; x, y unsigned 0..63
- busy_out  output  1  high while the clear sweep runs
- pipe_empty  output  1  no pixel in flight in the depth-test pipeline
- drop_err  output  1  sticky; a pixel arrived while busy_out=1
- rd_addr  input  12  display read address {y, x}
- rd_color  output  10  color at rd_addr, registered, 1-cycle latency
- stat_written  output  STAT_W  pixels committed since last clear
- stat_rejected  output  STAT_W  pixels failing the depth test since last clear

Behaviour:
- Memories:
  - Depth RAM is 4096x9, color RAM is 4096x10, both simple dual-port with synchronous read. Address is {y, x}.
  - RAM contents are not reset.
- FSM states:
  - CLEAR: addr_cnt steps 0..4095, writing CLEAR_DEPTH and CLEAR_COLOR each cycle. After the write to 4095 → IDLE.
  - IDLE: normal pixel processing.
- Reset:
  - rst_n low → state=CLEAR, addr_cnt=0, busy_out=1, pipe_empty=1, drop_err=0, rd_color=0, counters=0, pipeline valids=0.
  - rst_n low mid-sweep restarts the sweep from address 0.
- clear_in in IDLE:
  - The next cycle enters CLEAR with addr_cnt=0, busy_out=1.
  - In-flight pipeline pixels are discarded; no further writes from them.
  - drop_err and counters are cleared.
- clear_in during CLEAR: ignored.
- Sweep duration: busy_out is high for exactly 4096 cycles, then falls in the same cycle the state returns to IDLE.
- valid_in while busy_out=1: pixel dropped, drop_err<=1, RAMs unchanged by the pixel.
- Pipeline (IDLE), pixel sampled at edge N:
  - S0 (N+1): input registered; depth RAM read issued at {y, x}.
  - S1 (N+2): read data returned.
    - eff_depth = last_wr_z if last_wr_valid and last_wr_addr matches the pixel address, else RAM data.
    - Write both RAMs iff z < eff_depth (strict; equal z is rejected).
  - A committed pixel is visible on rd_color when rd_addr is presented at N+3 or later.
- Forwarding register: last_wr_{valid, addr, z} holds the S1 write of the previous cycle. It covers the read-during-write hazard so back-to-back same-address pixels test correctly. It is cleared on clear entry.
- Throughput: one pixel per cycle, sustained, no stalls.
- pipe_empty = !(S0 valid || S1 valid).
- Counters (see Optional Feature):
  - S1 commit increments stat_written; S1 reject increments stat_rejected.
  - Both saturate at all-ones.
- Display read port: independent of FSM state. During CLEAR it returns partially cleared contents.

Optional Feature:
- Macro ZBUF_STATS_EN.
- Defined: stat_written and stat_rejected counters are implemented as described.
- Undefined: both ports are tied to 0 and no counter logic is synthesized. All other behaviour is identical.

Test Plan:
- Release rst_n, count cycles → busy_out high for exactly 4096 cycles; afterwards rd_addr 12'h000 and 12'hFFF both return 10'h000.
- After clear, pixel x=5, y=3, z=100, color=10'h155 → rd_addr 12'h0C5 returns 10'h155 from N+3; stat_written=1; pipe_empty=1 by N+3.
- Same address: z=200/10'h0AA → rejected, color stays 10'h155; z=100/10'h0FF → rejected (tie); z=50/10'h2AA → rd_color 10'h2AA. Final stats: written=2, rejected=2.
- Three back-to-back cycles at x=10, y=10: z=300/10'h001, z=200/10'h002, z=250/10'h003 → 12'h28A returns 10'h002 (forwarding); written=2, rejected=1.
- clear_in, then valid_in one cycle later while busy → drop_err=1 and memory unchanged after the sweep. A following clear_in drops drop_err to 0.
- Assert rst_n low at sweep address ~2000, then release → busy_out remains high for a full 4096 cycles and all addresses read 10'h000.
